// File: rtl/vit_pkg.sv
// rtl/vit_pkg.sv - shared constants, FSM encoding and trellis symbol helper for the Viterbi ACS stage
package vit_pkg;
  localparam int NSTATES = 8;
  localparam int SW      = 3;
  localparam int MW      = 8;
  localparam int BMW     = 3;
  localparam int BW      = $clog2(MW);

  localparam logic [3:0]    G0      = 4'b1111;
  localparam logic [3:0]    G1      = 4'b1101;
  localparam logic [MW-1:0] INIT_PM = 8'd64;

  typedef enum logic [2:0] {IDLE, ADD0, ADD1, CMP, WR, SWAP} fsm_t;

  // Encoder output {c1,c0} for input bit u entering register state p.
  function automatic logic [1:0] sym_of(input logic u, input logic [SW-1:0] p);
    logic [3:0] r;
    r = {u, p};
    return {^(r & G1), ^(r & G0)};
  endfunction
endpackage

// File: rtl/acs_serial_sched_if.sv
// rtl/acs_serial_sched_if.sv - step request / decision result bundle for the serial ACS sequencer
interface acs_serial_sched_if;
  import vit_pkg::*;

  logic                 start;
  logic [4*BMW-1:0]     bm;
  logic                 ready;
  logic                 done;
  logic [NSTATES-1:0]   surv;
  logic [SW-1:0]        best_state;

  modport master (output start, bm, input ready, done, surv, best_state);
  modport slave  (input start, bm, output ready, done, surv, best_state);
endinterface

// File: rtl/acs_serial_sched_fa.sv
// rtl/acs_serial_sched_fa.sv - one-bit full adder shared by all path-metric additions
module fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/acs_serial_sched.sv
// rtl/acs_serial_sched.sv - bit-serial add-compare-select sequencer for an 8-state rate-1/2 Viterbi trellis
module acs_serial_sched
  import vit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  acs_serial_sched_if.slave  bus
);
  localparam logic [BW-1:0] BIT_LAST = BW'(MW - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(NSTATES - 1);

  fsm_t               st;
  logic [BW-1:0]      bit_cnt;
  logic [SW-1:0]      s_cnt;
  logic               carry;
  logic [MW-1:0]      cand0, cand1;
  logic               ovf0, ovf1;
  logic               dec_q;
  logic [MW-1:0]      win_q;
  logic [MW-1:0]      min_val;
  logic [SW-1:0]      min_idx;
  logic [NSTATES-1:0] surv_nxt;
  logic [4*BMW-1:0]   bm_q;
  logic               bank_sel;
  logic [MW-1:0]      pm [2][NSTATES];

  logic               ready_q, done_q;
  logic [NSTATES-1:0] surv_q;
  logic [SW-1:0]      best_q;

  assign bus.ready      = ready_q;
  assign bus.done       = done_q;
  assign bus.surv       = surv_q;
  assign bus.best_state = best_q;

  // ADD0 walks predecessor x=0, ADD1 walks x=1; reads always come from the active bank.
  logic               sel_x;
  logic [SW-1:0]      px;
  logic [1:0]         sym;
  logic [MW-1:0]      pm_rd;
  logic [BMW-1:0]     bm_sel;
  logic [MW-1:0]      bm_ext;
  logic               fa_s, fa_c;
  logic [MW-1:0]      fin0, fin1;
  logic               all_msb;

  assign sel_x  = (st == ADD1);
  assign px     = {s_cnt[SW-2:0], sel_x};
  assign sym    = sym_of(s_cnt[SW-1], px);
  assign pm_rd  = pm[bank_sel][px];
  assign bm_sel = bm_q[BMW*int'(sym) +: BMW];
  assign bm_ext = {{(MW-BMW){1'b0}}, bm_sel};
  assign fin0   = ovf0 ? '1 : cand0;
  assign fin1   = ovf1 ? '1 : cand1;

  fa u_fa (
    .x    (pm_rd[bit_cnt]),
    .y    (bm_ext[bit_cnt]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    all_msb = 1'b1;
    for (int i = 0; i < NSTATES; i++) all_msb = all_msb & pm[~bank_sel][i][MW-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      surv_q   <= '0;
      best_q   <= '0;
      bank_sel <= 1'b0;
      bit_cnt  <= '0;
      s_cnt    <= '0;
      carry    <= 1'b0;
      cand0    <= '0;
      cand1    <= '0;
      ovf0     <= 1'b0;
      ovf1     <= 1'b0;
      dec_q    <= 1'b0;
      win_q    <= '0;
      min_val  <= '0;
      min_idx  <= '0;
      surv_nxt <= '0;
      bm_q     <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NSTATES; i++)
          pm[b][i] <= (i == 0) ? '0 : INIT_PM;
    end else begin
      done_q <= 1'b0;
      case (st)
        IDLE: begin
          if (bus.start && ready_q) begin
            bm_q    <= bus.bm;
            ready_q <= 1'b0;
            bit_cnt <= '0;
            s_cnt   <= '0;
            carry   <= 1'b0;
            st      <= ADD0;
          end
        end
        ADD0: begin
          cand0   <= {fa_s, cand0[MW-1:1]};
          carry   <= fa_c;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            ovf0    <= fa_c;
            carry   <= 1'b0;
            bit_cnt <= '0;
            st      <= ADD1;
          end
        end
        ADD1: begin
          cand1   <= {fa_s, cand1[MW-1:1]};
          carry   <= fa_c;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            ovf1    <= fa_c;
            carry   <= 1'b0;
            bit_cnt <= '0;
            st      <= CMP;
          end
        end
        CMP: begin
          dec_q <= (fin1 < fin0);
          win_q <= (fin1 < fin0) ? fin1 : fin0;
          st    <= WR;
        end
        WR: begin
          pm[~bank_sel][s_cnt] <= win_q;
          surv_nxt[s_cnt]      <= dec_q;
          if (s_cnt == '0 || win_q < min_val) begin
            min_val <= win_q;
            min_idx <= s_cnt;
          end
          if (s_cnt == S_LAST) begin
            st <= SWAP;
          end else begin
            s_cnt <= s_cnt + 1'b1;
            st    <= ADD0;
          end
        end
        SWAP: begin
          // Uniform subtraction of 2^(MW-1) keeps metric differences intact.
          if (all_msb)
            for (int i = 0; i < NSTATES; i++) pm[~bank_sel][i][MW-1] <= 1'b0;
          bank_sel <= ~bank_sel;
          surv_q   <= surv_nxt;
          best_q   <= min_idx;
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
          st       <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acs_serial_sched.sv
// tb/tb_acs_serial_sched.sv - scoreboard bench for acs_serial_sched
module tb_acs_serial_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acs_serial_sched_if ifc ();
  acs_serial_sched dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    logic [7:0]  surv;
    logic [2:0]  best;
    logic [63:0] pm;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     passes = 0;
  int     cyc = 0;
  int     done_cnt = 0;
  bit     prev_done = 1'b0;
  int     mpm[8];
  longint upm[8];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic read_pm(output logic [63:0] v);
    for (int i = 0; i < 8; i++) v[8*i +: 8] = dut.pm[dut.bank_sel][i];
  endtask

  function automatic int bsym(input int u, input int px);
    logic [3:0] r;
    logic c0, c1;
    r  = {u[0], px[2:0]};
    c0 = r[3] ^ r[2] ^ r[1] ^ r[0];
    c1 = r[3] ^ r[2] ^ r[0];
    return c1 * 2 + c0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mpm[i] = (i == 0) ? 0 : 64;
      upm[i] = (i == 0) ? 0 : 64;
    end
  endtask

  task automatic model_step(input logic [11:0] b, output exp_t e);
    int     np[8];
    longint nu[8];
    int     c[2];
    longint cu[2];
    int     ubi;
    bit     all_hi;
    e.surv = '0;
    for (int s = 0; s < 8; s++) begin
      for (int x = 0; x < 2; x++) begin
        int px, bmv;
        px    = ((s & 3) << 1) | x;
        bmv   = int'((b >> (3 * bsym(s >> 2, px))) & 12'd7);
        c[x]  = mpm[px] + bmv;
        if (c[x] > 255) c[x] = 255;
        cu[x] = upm[px] + bmv;
      end
      e.surv[s] = (c[1] < c[0]);
      np[s]     = (c[1] < c[0]) ? c[1] : c[0];
      nu[s]     = (cu[1] < cu[0]) ? cu[1] : cu[0];
    end
    ubi = 0;
    for (int s = 1; s < 8; s++) if (nu[s] < nu[ubi]) ubi = s;
    e.best = 3'(ubi);
    all_hi = 1'b1;
    for (int s = 0; s < 8; s++) if (np[s] < 128) all_hi = 1'b0;
    for (int s = 0; s < 8; s++) begin
      if (all_hi) np[s] -= 128;
      mpm[s]         = np[s];
      upm[s]         = nu[s];
      e.pm[8*s +: 8] = 8'(np[s]);
    end
    e.acc = 0;
    e.lat = 1'b0;
  endtask

  always @(negedge clk) begin
    if (prev_done) chk("done_width", 64'(ifc.done), 64'd0);
    if (ifc.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        logic [63:0] v;
        e = sb.pop_front();
        read_pm(v);
        chk("surv", 64'(ifc.surv), 64'(e.surv));
        chk("best_state", 64'(ifc.best_state), 64'(e.best));
        chk("pm_bank", v, e.pm);
        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd145);
      end
    end
    prev_done = ifc.done;
  end

  task automatic issue(input logic [11:0] b, output int acc);
    int n = 0;
    while (!ifc.ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(ifc.ready), 64'd1);
    ifc.start = 1'b1;
    ifc.bm    = b;
    @(posedge clk);
    #1;
    acc       = cyc;
    ifc.start = 1'b0;
  endtask

  task automatic push_model(input logic [11:0] b, input int acc, input bit lat);
    exp_t e;
    model_step(b, e);
    e.acc = acc;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic push_hand(input logic [11:0] b, input int acc, input logic [7:0] sv,
                           input logic [2:0] bs, input logic [63:0] pmv);
    exp_t e, dummy;
    model_step(b, dummy);
    e.surv = sv;
    e.best = bs;
    e.pm   = pmv;
    e.acc  = acc;
    e.lat  = 1'b1;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !ifc.ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("step_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  localparam logic [63:0] PM_RST = 64'h40404040_40404000;
  localparam logic [63:0] PM_T2  = 64'h40404000_40404000;
  localparam logic [63:0] PM_T3  = 64'h41404103_41404100;
  localparam logic [11:0] BM_T3  = {3'd3, 3'd1, 3'd2, 3'd0};

  initial begin
    int          acc, c0;
    logic [63:0] v;
    rst       = 1'b1;
    ifc.start = 1'b0;
    ifc.bm    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();

    repeat (10) @(negedge clk);
    chk("rst_ready", 64'(ifc.ready), 64'd1);
    chk("rst_done", 64'(ifc.done), 64'd0);
    chk("rst_surv", 64'(ifc.surv), 64'd0);
    chk("rst_best", 64'(ifc.best_state), 64'd0);
    read_pm(v);
    chk("rst_pm", v, PM_RST);

    issue(12'h000, acc);
    push_hand(12'h000, acc, 8'h00, 3'd0, PM_T2);
    wait_idle();

    do_reset();
    issue(BM_T3, acc);
    push_hand(BM_T3, acc, 8'h86, 3'd0, PM_T3);
    wait_idle();

    c0 = done_cnt;
    issue(12'h29c, acc);
    push_model(12'h29c, acc, 1'b1);
    repeat (20) @(negedge clk);
    chk("busy_ready_a", 64'(ifc.ready), 64'd0);
    ifc.start = 1'b1;
    ifc.bm    = 12'hfff;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("busy_ready_b", 64'(ifc.ready), 64'd0);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("one_done", 64'(done_cnt - c0), 64'd1);

    c0 = done_cnt;
    issue(12'h123, acc);
    repeat (70) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (200) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - c0), 64'd0);
    chk("abort_ready", 64'(ifc.ready), 64'd1);
    read_pm(v);
    chk("abort_pm", v, PM_RST);
    issue(12'h000, acc);
    push_hand(12'h000, acc, 8'h00, 3'd0, PM_T2);
    wait_idle();

    do_reset();
    for (int k = 0; k < 200; k++) begin
      issue(12'hfff, acc);
      push_model(12'hfff, acc, 1'b1);
    end
    wait_idle();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
